// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte, halfword and word accesses
// onto a word-wide data memory with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LP_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_bad;
  logic        w_accept;
  logic        w_word_st;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_word_st = req_write && (req_size == 2'b10);

  // Classify the incoming request: bad size, misalignment or out of range.
  always_comb begin
    w_bad = 1'b0;
    unique case (req_size)
      2'b00:   w_bad = 1'b0;
      2'b01:   w_bad = req_addr[0];
      2'b10:   w_bad = |req_addr[1:0];
      default: w_bad = 1'b1;
    endcase
    if (req_addr >= LP_LIMIT) begin
      w_bad = 1'b1;
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ext  = mem_rdata;
    unique case (r_size)
      2'b00:   w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  // Overlay the store lanes onto the word read back from memory.
  always_comb begin
    w_merge = mem_rdata;
    if (r_size == 2'b00) begin
      w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  // Next-state decode for the access sequencer.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_bad) begin
            w_next = RESP;
          end else if (w_word_st) begin
            w_next = WR;
          end else begin
            w_next = RD;
          end
        end
      end
      RD:      w_next = CAP;
      CAP:     w_next = r_write ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latch, store-word build and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_off        <= 2'b00;
      r_wdata      <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_uns      <= req_unsigned;
        r_off      <= req_addr[1:0];
        r_wdata    <= req_wdata[15:0];
        r_mem_addr <= {req_addr[31:2], 2'b00};
        if (!w_bad && w_word_st) begin
          r_mem_wdata <= req_wdata;
        end
      end
      if (r_state == CAP && r_write) begin
        r_mem_wdata <= w_merge;
      end
      // Response fields only change on entry to RESP so they hold between.
      if (w_next == RESP && r_state != RESP) begin
        r_resp_err   <= (r_state == IDLE) ? w_bad : 1'b0;
        r_resp_rdata <= (r_state == CAP && !r_write) ? w_ext : 32'h0;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign resp_valid = (r_state == RESP) & ~reset;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_read   = (r_state == RD) & ~reset;
  assign mem_write  = (r_state == WR) & ~reset;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The module SHALL have one parameter: MEM_BYTES, default 1024, byte size of the downstream data memory.
REQ-002 The module SHALL have a single clock and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: req_valid  input  1  memory-stage request strobe.
REQ-006 Port: req_write  input  1  1 = store, 0 = load.
REQ-007 Port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 Port: req_unsigned  input  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-009 Port: req_addr  input  32  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-justified.
REQ-011 Port: busy  output  1  high while a request is in flight; the pipeline stalls on it.
REQ-012 Port: resp_valid  output  1  one-cycle completion pulse.
REQ-013 Port: resp_err  output  1  qualifies resp_valid; high for a misaligned, out-of-range or illegal-size request.
REQ-014 Port: resp_rdata  output  32  load result, valid with resp_valid.
REQ-015 Port: mem_read, mem_write  output  1 each  data-memory strobes.
REQ-016 Port: mem_addr  output  32  always word-aligned, {addr[31:2],2'b00}.
REQ-017 Port: mem_wdata  output  32  little-endian word to memory; byte 0 is on bits [7:0].
REQ-018 Port: mem_rdata  input  32  memory read word, valid in the cycle after a mem_read cycle.

Function
REQ-019 The FSM SHALL have the states IDLE, RD, CAP, WR and RESP, with busy = (state != IDLE).
REQ-020 A request SHALL be accepted only on a clock edge where state is IDLE and req_valid=1; all req_* SHALL be latched at that edge.
REQ-021 Error check at accept: size 11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr >= MEM_BYTES → RESP with the error flag set, and mem strobes never assert.
REQ-022 Accepted load or sub-word store → RD; accepted word store → WR.
REQ-023 RD: mem_read=1 for exactly one cycle, then CAP.
REQ-024 CAP, load: extract the result into a register, then RESP.
REQ-025 CAP, sub-word store: merge the store data into mem_rdata, latch the merged word, then WR.
REQ-026 WR: mem_write=1 for exactly one cycle with mem_wdata, then RESP.
REQ-027 RESP: resp_valid=1 for exactly one cycle, then IDLE; resp_err and resp_rdata SHALL hold until the next RESP.
REQ-028 Latency from the accept edge to the resp_valid cycle SHALL be: error 1, word store 2, load 3, sub-word store 4 cycles.
REQ-029 Byte extraction SHALL take offset o=addr[1:0] and use bits [8o+7:8o]; halfword extraction SHALL use addr[1] and bits [16h+15:16h].
REQ-030 Extraction SHALL sign- or zero-extend to 32 bits per req_unsigned; word loads SHALL pass mem_rdata unchanged.
REQ-031 Sub-word merge SHALL replace only the addressed byte or halfword lanes with req_wdata[7:0] or [15:0], preserving all other lanes.
REQ-032 mem_read and mem_write SHALL never be high in the same cycle.
REQ-033 mem_read and mem_write SHALL be decoded from state and gated by ~reset.
REQ-034 req_valid while busy SHALL be ignored; the requester holds its request until busy falls.

Reset
REQ-035 Reset SHALL force IDLE at the next edge; busy, resp_valid, resp_err, mem_read and mem_write SHALL be 0; resp_rdata, mem_wdata and mem_addr SHALL be 0.
REQ-036 Reset asserted in any state SHALL abort the operation with no partial write and no resp_valid, and mem strobes SHALL be 0 in the reset cycle itself.
REQ-037 Reset SHALL take priority over a simultaneous req_valid.

Verification
REQ-038 Memory bytes 4..7 = 04,05,06,07; lw addr 4 → mem_read in cycle 1, resp_valid in cycle 3, resp_rdata=0x07060504, resp_err=0.
REQ-039 sb 0x80 to addr 5 → RD, CAP, then WR with mem_wdata=0x07068004; lb addr 5 → 0xFFFFFF80; lbu addr 5 → 0x00000080.
REQ-040 sh 0xBEEF to addr 6 after REQ-039 → mem_wdata=0xBEEF8004; lh addr 6 → 0xFFFFBEEF; lhu addr 6 → 0x0000BEEF.
REQ-041 lw addr 2, sh addr 3, size 11 and lw addr 1024 → resp_valid with resp_err=1 one cycle after accept; mem_read and mem_write stay 0 throughout.
REQ-042 sb to addr 4 with reset asserted during CAP → no mem_write, no resp_valid, busy=0 after the edge, and a later lw addr 4 returns the unchanged word.
REQ-043 req_valid held high across back-to-back lw addr 4 requests → the second is accepted only after RESP, so each request takes 4 cycles from accept to the next accept.
